// File: rtl/sync_width_conv_fifo.sv
// Single-clock FIFO with power-of-two width conversion and selectable lane order.
// Storage is a ring of narrow units; each write/read moves WR/RR units at once.
module sync_width_conv_fifo #(
  parameter int DIN_WIDTH        = 288,
  parameter int DOUT_WIDTH       = 144,
  parameter int DEPTH            = 16,
  parameter bit MSB_FIRST        = 1'b1,
  parameter int PROG_FULL_THRESH = 12,
  localparam int NW  = (DIN_WIDTH < DOUT_WIDTH) ? DIN_WIDTH : DOUT_WIDTH,
  localparam int R   = ((DIN_WIDTH > DOUT_WIDTH) ? DIN_WIDTH : DOUT_WIDTH) / NW,
  localparam int CAP = DEPTH * R,
  localparam int CW  = $clog2(CAP) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DIN_WIDTH-1:0]  din,
  output logic                  full,
  output logic                  prog_full,
  input  logic                  rd_en,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  empty,
  output logic [CW-1:0]         wr_count,
  output logic [CW-1:0]         rd_count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int WR = DIN_WIDTH / NW;
  localparam int RR = DOUT_WIDTH / NW;
  localparam int AW = $clog2(CAP);
  localparam int WS = $clog2(WR);
  localparam int RS = $clog2(RR);

  logic [NW-1:0]         mem [CAP];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         units;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [DOUT_WIDTH-1:0] rd_word;

  // Partially filled write words still count as occupied on the write side.
  function automatic logic [CW-1:0] ceil_units_to_words(input logic [CW-1:0] u);
    logic [CW:0] s;
    s = {1'b0, u} + (CW+1)'(WR - 1);
    return CW'(s >> WS);
  endfunction

  assign full      = (units > CW'(CAP - WR));
  assign empty     = (units < CW'(RR));
  assign wr_count  = ceil_units_to_words(units);
  assign rd_count  = units >> RS;
  assign prog_full = ({1'b0, wr_count} >= (CW+1)'(PROG_FULL_THRESH));
  assign wr_acc    = wr_en && !full;
  assign rd_acc    = rd_en && !empty;

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < RR; k++) begin
      if (MSB_FIRST) rd_word[(RR-1-k)*NW +: NW] = mem[rd_ptr + AW'(k)];
      else           rd_word[k*NW +: NW]        = mem[rd_ptr + AW'(k)];
    end
  end

  // Write stage: scatter din lanes into consecutive units in time order.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int k = 0; k < WR; k++) begin
        if (MSB_FIRST) mem[wr_ptr + AW'(k)] <= din[(WR-1-k)*NW +: NW];
        else           mem[wr_ptr + AW'(k)] <= din[k*NW +: NW];
      end
    end
  end

  // Control and registered read data; reset clears dout so nothing stale leaks out.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      units     <= '0;
      dout      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
      if (wr_acc) wr_ptr <= wr_ptr + AW'(WR);
      if (rd_acc) begin
        rd_ptr <= rd_ptr + AW'(RR);
        dout   <= rd_word;
      end
      units <= units + (wr_acc ? CW'(WR) : '0) - (rd_acc ? CW'(RR) : '0);
    end
  end

endmodule
